// File: rtl/simon_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : simon_pkg
// Brief  : Shared state encoding, mode LED codes and pattern legality rule.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package simon_pkg;

    typedef enum logic [1:0] {
        S_INPUT    = 2'd0,
        S_PLAYBACK = 2'd1,
        S_REPEAT   = 2'd2,
        S_DONE     = 2'd3
    } state_e;

    localparam logic [3:0] c_MODE_INPUT    = 4'b0001;
    localparam logic [3:0] c_MODE_PLAYBACK = 4'b0010;
    localparam logic [3:0] c_MODE_REPEAT   = 4'b0100;
    localparam logic [3:0] c_MODE_DONE     = 4'b1000;

    localparam int c_MAX_BTN = 32;

    // Callers zero-extend their pattern to c_MAX_BTN bits.
    function automatic logic is_legal(input logic [c_MAX_BTN-1:0] pattern, input logic level);
        return (pattern != '0) && (level || $onehot(pattern));
    endfunction

endpackage
`default_nettype wire

// File: rtl/simon_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : simon_if
// Brief  : Player-facing bundle of the Simon engine (buttons in, LEDs out).
// Rev    : 1.0
// ---------------------------------------------------------------------------
interface simon_if #(
    parameter int NUM_BTN = 4,
    parameter int CNT_W   = 7
);
    logic               level;
    logic [NUM_BTN-1:0] pattern;
    logic               pattern_vld;
    logic [NUM_BTN-1:0] pattern_leds;
    logic [3:0]         mode_leds;
    logic [CNT_W-1:0]   score;
    logic               win;

    modport master (
        output level, pattern, pattern_vld,
        input  pattern_leds, mode_leds, score, win
    );

    modport slave (
        input  level, pattern, pattern_vld,
        output pattern_leds, mode_leds, score, win
    );
endinterface
`default_nettype wire

// File: rtl/simon_seq_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : simon_seq_mem
// Brief  : Sequence store, one synchronous write port and one async read port.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module simon_seq_mem #(
    parameter int NUM_BTN = 4,
    parameter int DEPTH   = 64
) (
    input  wire logic                     clk_i,
    input  wire logic                     we_i,
    input  wire logic [$clog2(DEPTH)-1:0] waddr_i,
    input  wire logic [NUM_BTN-1:0]       wdata_i,
    input  wire logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic      [NUM_BTN-1:0]       rdata_o
);
    // Left unreset: the entry count masks stale contents after a reset.
    logic [NUM_BTN-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/simon_core_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : simon_core_param
// Brief  : Simon game engine - control FSM, sequence memory, playback timing.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module simon_core_param
    import simon_pkg::*;
#(
    parameter int NUM_BTN    = 4,
    parameter int DEPTH      = 64,
    parameter int PLAY_TICKS = 4
) (
    input  wire logic pclk,
    input  wire logic rst,
    simon_if.slave    bus
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int TICK_W = (PLAY_TICKS > 1) ? $clog2(PLAY_TICKS) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic               win_q, win_d;
    logic               level_q;

    logic               mem_we;
    logic [NUM_BTN-1:0] mem_rdata;
    logic [NUM_BTN-1:0] leds;
    logic [3:0]         mode;
    logic               idx_last;
    logic               tick_end;

    simon_seq_mem #(
        .NUM_BTN (NUM_BTN),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk_i   (pclk),
        .we_i    (mem_we),
        .waddr_i (IDX_W'(count_q)),
        .wdata_i (bus.pattern),
        .raddr_i (idx_q),
        .rdata_o (mem_rdata)
    );

    assign idx_last = (CNT_W'(idx_q) == (count_q - CNT_W'(1)));
    assign tick_end = (tick_q == TICK_W'(PLAY_TICKS - 1));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        tick_d  = tick_q;
        win_d   = win_q;
        mem_we  = 1'b0;
        leds    = bus.pattern;
        case (state_q)
            S_INPUT: begin
                if (bus.pattern_vld && is_legal(c_MAX_BTN'(bus.pattern), level_q)) begin
                    mem_we  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    idx_d   = '0;
                    tick_d  = '0;
                    state_d = S_PLAYBACK;
                end
            end
            S_PLAYBACK, S_DONE: begin
                leds = mem_rdata;
                if (tick_end) begin
                    tick_d = '0;
                    if (idx_last) begin
                        idx_d = '0;
                        // DONE keeps looping the sequence until reset.
                        if (state_q == S_PLAYBACK) begin
                            state_d = S_REPEAT;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_REPEAT: begin
                if (bus.pattern_vld) begin
                    if (bus.pattern == mem_rdata) begin
                        if (idx_last) begin
                            idx_d  = '0;
                            tick_d = '0;
                            if (count_q == CNT_W'(DEPTH)) begin
                                state_d = S_DONE;
                                win_d   = 1'b1;
                            end else begin
                                state_d = S_INPUT;
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        state_d = S_DONE;
                        idx_d   = '0;
                        tick_d  = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        mode = c_MODE_INPUT;
        case (state_q)
            S_INPUT:    mode = c_MODE_INPUT;
            S_PLAYBACK: mode = c_MODE_PLAYBACK;
            S_REPEAT:   mode = c_MODE_REPEAT;
            S_DONE:     mode = c_MODE_DONE;
            default:    mode = c_MODE_INPUT;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INPUT;
            count_q <= '0;
            idx_q   <= '0;
            tick_q  <= '0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            win_q   <= win_d;
        end
    end

    // Difficulty tracks the switch only while held in reset.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            level_q <= bus.level;
        end
    end

    assign bus.pattern_leds = leds;
    assign bus.mode_leds    = mode;
    assign bus.score        = count_q;
    assign bus.win          = win_q;

endmodule
`default_nettype wire

// File: tb/tb_simon_core_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_simon_core_param
// Brief  : Randomized self-checking bench against a queue-based game model.
// ---------------------------------------------------------------------------
module tb_simon_core_param;
    localparam int NB = 4;
    localparam int DP = 4;
    localparam int PT = 2;
    localparam int CW = 3;

    localparam logic [3:0] M_IN = 4'b0001;
    localparam logic [3:0] M_PB = 4'b0010;
    localparam logic [3:0] M_RP = 4'b0100;
    localparam logic [3:0] M_DN = 4'b1000;

    logic pclk = 1'b0;
    logic rst  = 1'b0;

    simon_if #(.NUM_BTN(NB), .CNT_W(CW)) bus_if ();

    simon_core_param #(
        .NUM_BTN    (NB),
        .DEPTH      (DP),
        .PLAY_TICKS (PT)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus_if)
    );

    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;
    logic [NB-1:0] seq_m [$];

    function automatic logic legal_m(input logic [NB-1:0] p, input logic lv);
        return (p != '0) && (lv || ($countones(p) == 1));
    endfunction

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset(input logic lv);
        bus_if.pattern_vld = 1'b0;
        bus_if.pattern     = '0;
        bus_if.level       = lv;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        seq_m.delete();
    endtask

    task automatic strobe(input logic [NB-1:0] p);
        bus_if.pattern     = p;
        bus_if.pattern_vld = 1'b1;
        step();
        bus_if.pattern_vld = 1'b0;
    endtask

    // Submit p, watch playback, then replay (optionally wrong at wrong_at).
    task automatic run_round(input logic [NB-1:0] p, input bit noise,
                             input int wrong_at, input logic [NB-1:0] wrong_p);
        int n;
        logic [NB-1:0] pat;
        strobe(p);
        seq_m.push_back(p);
        n = seq_m.size();
        for (int k = 0; k < n * PT; k++) begin
            checks++;
            if (bus_if.mode_leds !== M_PB || bus_if.pattern_leds !== seq_m[k / PT]) begin
                errors++;
                $display("FAIL playback k=%0d mode=%b leds=%b expected mode=%b leds=%b",
                         k, bus_if.mode_leds, bus_if.pattern_leds, M_PB, seq_m[k / PT]);
            end
            if (noise) begin
                bus_if.pattern     = NB'($urandom_range(0, 15));
                bus_if.pattern_vld = 1'b1;
            end
            step();
        end
        bus_if.pattern_vld = 1'b0;
        checks++;
        if (bus_if.mode_leds !== M_RP) begin
            errors++;
            $display("FAIL enter_repeat mode=%b expected %b", bus_if.mode_leds, M_RP);
        end
        for (int i = 0; i < n; i++) begin
            pat = (i == wrong_at) ? wrong_p : seq_m[i];
            bus_if.pattern     = pat;
            bus_if.pattern_vld = 1'b1;
            #1;
            checks++;
            if (bus_if.pattern_leds !== pat) begin
                errors++;
                $display("FAIL repeat_echo leds=%b expected %b", bus_if.pattern_leds, pat);
            end
            step();
            bus_if.pattern_vld = 1'b0;
            if (i == wrong_at) begin
                checks++;
                if (bus_if.mode_leds !== M_DN || bus_if.win !== 1'b0) begin
                    errors++;
                    $display("FAIL mismatch_done mode=%b win=%b expected mode=%b win=0",
                             bus_if.mode_leds, bus_if.win, M_DN);
                end
                return;
            end
            if (i < n - 1) begin
                checks++;
                if (bus_if.mode_leds !== M_RP) begin
                    errors++;
                    $display("FAIL repeat_stay i=%0d mode=%b expected %b", i, bus_if.mode_leds, M_RP);
                end
            end
        end
        checks++;
        if (bus_if.mode_leds !== ((n == DP) ? M_DN : M_IN) || bus_if.win !== (n == DP)
            || bus_if.score !== CW'(n)) begin
            errors++;
            $display("FAIL round_end mode=%b win=%b score=%0d expected mode=%b win=%0d score=%0d",
                     bus_if.mode_leds, bus_if.win, bus_if.score,
                     (n == DP) ? M_DN : M_IN, (n == DP), n);
        end
    endtask

    // Cycle through the DONE display for the given length, optionally strobing.
    task automatic check_done(input int cycles, input bit noise, input logic exp_win);
        int n;
        n = seq_m.size();
        for (int k = 0; k < cycles; k++) begin
            checks++;
            if (bus_if.mode_leds !== M_DN || bus_if.pattern_leds !== seq_m[(k / PT) % n]
                || bus_if.win !== exp_win || bus_if.score !== CW'(n)) begin
                errors++;
                $display("FAIL done_loop k=%0d mode=%b leds=%b win=%b score=%0d expected leds=%b win=%b score=%0d",
                         k, bus_if.mode_leds, bus_if.pattern_leds, bus_if.win, bus_if.score,
                         seq_m[(k / PT) % n], exp_win, n);
            end
            if (noise) begin
                bus_if.pattern     = NB'($urandom_range(1, 15));
                bus_if.pattern_vld = 1'b1;
            end
            step();
        end
        bus_if.pattern_vld = 1'b0;
    endtask

    task automatic test_reset();
        bus_if.pattern_vld = 1'b0;
        bus_if.pattern     = '0;
        bus_if.level       = 1'b0;
        rst = 1'b0;
        step();
        checks++;
        if (bus_if.mode_leds !== M_IN || bus_if.score !== '0 || bus_if.win !== 1'b0) begin
            errors++;
            $display("FAIL reset_state mode=%b score=%0d win=%b expected mode=%b score=0 win=0",
                     bus_if.mode_leds, bus_if.score, bus_if.win, M_IN);
        end
        do_reset(1'b0);
        bus_if.pattern = NB'($urandom_range(0, 15));
        #1;
        checks++;
        if (bus_if.pattern_leds !== bus_if.pattern || bus_if.mode_leds !== M_IN) begin
            errors++;
            $display("FAIL input_echo leds=%b mode=%b expected leds=%b mode=%b",
                     bus_if.pattern_leds, bus_if.mode_leds, bus_if.pattern, M_IN);
        end
    endtask

    task automatic test_basic();
        do_reset(1'b0);
        run_round(4'b0010, 1'b0, -1, '0);
    endtask

    task automatic test_illegal();
        do_reset(1'b0);
        strobe(4'b0110);
        checks++;
        if (bus_if.mode_leds !== M_IN || bus_if.score !== '0) begin
            errors++;
            $display("FAIL illegal_two_bits mode=%b score=%0d expected mode=%b score=0",
                     bus_if.mode_leds, bus_if.score, M_IN);
        end
        strobe(4'b0000);
        checks++;
        if (bus_if.mode_leds !== M_IN || bus_if.score !== '0) begin
            errors++;
            $display("FAIL illegal_zero mode=%b score=%0d expected mode=%b score=0",
                     bus_if.mode_leds, bus_if.score, M_IN);
        end
        do_reset(1'b1);
        run_round(4'b0110, 1'b0, -1, '0);
    endtask

    task automatic test_mismatch();
        do_reset(1'b0);
        run_round(4'b0001, 1'b0, -1, '0);
        run_round(4'b0100, 1'b0, 1, 4'b1000);
        check_done(5 * PT, 1'b0, 1'b0);
    endtask

    task automatic test_win();
        do_reset(1'b1);
        for (int r = 0; r < DP; r++) begin
            run_round(NB'($urandom_range(1, 15)), 1'b1, -1, '0);
        end
        check_done(3 * DP * PT, 1'b1, 1'b1);
    endtask

    task automatic test_level_freeze();
        do_reset(1'b0);
        bus_if.level = 1'b1;
        step();
        strobe(4'b0110);
        checks++;
        if (bus_if.mode_leds !== M_IN || bus_if.score !== '0) begin
            errors++;
            $display("FAIL level_frozen_easy mode=%b score=%0d expected mode=%b score=0",
                     bus_if.mode_leds, bus_if.score, M_IN);
        end
        do_reset(1'b1);
        bus_if.level = 1'b0;
        step();
        run_round(4'b1010, 1'b0, -1, '0);
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        run_round(4'b0001, 1'b0, -1, '0);
        strobe(4'b1000);
        step();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus_if.mode_leds !== M_IN || bus_if.score !== '0 || bus_if.win !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid mode=%b score=%0d win=%b expected mode=%b score=0 win=0",
                     bus_if.mode_leds, bus_if.score, bus_if.win, M_IN);
        end
        step();
        rst = 1'b1;
        seq_m.delete();
        run_round(4'b0100, 1'b0, -1, '0);
    endtask

    task automatic test_random_games();
        logic          lv;
        logic [NB-1:0] p;
        logic [NB-1:0] target;
        int            wa;
        for (int g = 0; g < 4; g++) begin
            lv = 1'($urandom_range(0, 1));
            do_reset(lv);
            for (int it = 0; it < 24; it++) begin
                p = NB'($urandom_range(0, 15));
                if (!legal_m(p, lv)) begin
                    strobe(p);
                    checks++;
                    if (bus_if.mode_leds !== M_IN || bus_if.score !== CW'(seq_m.size())) begin
                        errors++;
                        $display("FAIL rand_reject p=%b mode=%b score=%0d expected mode=%b score=%0d",
                                 p, bus_if.mode_leds, bus_if.score, M_IN, seq_m.size());
                    end
                end else begin
                    wa = -1;
                    if ($urandom_range(0, 3) == 0) begin
                        wa = $urandom_range(0, seq_m.size());
                        target = (wa == seq_m.size()) ? p : seq_m[wa];
                    end else begin
                        target = '0;
                    end
                    run_round(p, 1'($urandom_range(0, 1)), wa, target ^ NB'($urandom_range(1, 15)));
                    if (wa >= 0) begin
                        check_done(2 * seq_m.size() * PT, 1'b1, 1'b0);
                        break;
                    end
                    if (seq_m.size() == DP) begin
                        check_done(DP * PT, 1'b0, 1'b1);
                        break;
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_mismatch();
        test_win();
        test_level_freeze();
        test_reset_mid();
        test_random_games();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
